cic_dec_ctrl: RTL and testbench
===============================

// Module: cic_dec_ctrl
// PURPOSE
//  Sequencer for the cic_compiler_v2_0 decimator in the receive chain. Issues the core's
//  clear, gates ADC samples into it against rfd, and discards the first outputs after a clear.
//  Buffers decimated outputs in a 2-entry FIFO toward the downstream (USB/FIFO) side and
//  counts input and output overruns.
// PARAMETERS
//  DW           18  sample width, in and out
//  SCLR_CYCLES   4  cycles cic_sclr is held high per clear (>=1)
//  FLUSH_OUTS    3  rdy pulses discarded after clear for filter settling (0 = none)
//  CNT_W        16  width of drop counters (saturating)
// PORTS
//  clk           in   1     system clock (80 MHz)
//  sclr          in   1     async active-high reset
//  restart       in   1     sync pulse: re-clear core, empty FIFO, re-enter CLEAR
//  in_valid      in   1     ADC sample strobe
//  in_data       in   DW    ADC sample, signed
//  cic_sclr      out  1     clear to CIC core
//  cic_din       out  DW    sample to CIC core
//  cic_nd        out  1     new-data strobe to core (ignored if core built without ND)
//  cic_rfd       in   1     core ready-for-data
//  cic_rdy       in   1     core output valid
//  cic_dout      in   DW    core output, signed
//  out_valid     out  1     FIFO head valid
//  out_data      out  DW    FIFO head
//  out_ready     in   1     downstream accept
//  running       out  1     state == RUN
//  in_drop_cnt   out  CNT_W samples lost to rfd low (RUN/FLUSH only)
//  out_drop_cnt  out  CNT_W outputs lost to full FIFO
// BEHAVIOUR
//  Reset (sclr high): state=CLEAR, sclr counter=SCLR_CYCLES, cic_sclr=1, cic_din=0, cic_nd=0,
//   FIFO empty, out_valid=0, out_data=0, running=0, both drop counters=0.
//  States: CLEAR -> WAIT_RFD -> FLUSH -> RUN.
//   CLEAR: cic_sclr=1 exactly SCLR_CYCLES cycles, then WAIT_RFD.
//   WAIT_RFD: cic_sclr=0; first cycle cic_rfd=1 -> FLUSH (or RUN if FLUSH_OUTS=0).
//   FLUSH: each cic_rdy decrements flush count, output discarded; at 0 -> RUN.
//   RUN: outputs pushed to FIFO. running=1 registered, this state only.
//  restart in any state: next cycle CLEAR, counter reloaded, FIFO emptied;
//   drop counters keep their values. restart wins over any same-cycle event.
//  Input path (FLUSH/RUN): in_valid & cic_rfd -> cic_din<=in_data, cic_nd=1 next cycle.
//   in_valid & !cic_rfd -> sample dropped, in_drop_cnt+1, saturating at all-ones.
//   CLEAR/WAIT_RFD: samples ignored, not counted, cic_din held 0, cic_nd=0.
//  Output path: latency cic_rdy -> out_valid = 1 cycle when FIFO empty.
//   Pop on out_valid & out_ready. Push and pop in same cycle always allowed, including when full.
//   Full, no pop, cic_rdy in RUN -> output dropped, out_drop_cnt+1 (saturating).
//   FIFO strictly in order; no data passes straight through when FIFO empty.
//  No arithmetic on samples; widths pass through unchanged.
// STRUCTURE
//  cic_dec_ctrl_defs.vh: state encodings (2-bit: CLEAR=0, WAIT_RFD=1, FLUSH=2, RUN=3),
//   default DW.
//  Sub-module cic_out_fifo: 2-entry FWFT register FIFO, push/pop/flush, full/empty.
//  FSM, sclr/flush counters, input gating and drop counters stay in cic_dec_ctrl.
// TESTING (core modelled as behavioural stub with settable rfd/rdy pattern, 12.5 ns clk)
//  1 reset: sclr high 100 ns -> all outputs at reset values.
//    Release -> cic_sclr high exactly 4 clk, then low.
//  2 bring-up: rfd=1 after clear, rdy every 8 clk, din=100 constant ->
//    first 3 rdy not output; 4th gives out_valid=1 one clk later; running=1.
//  3 input overrun: rfd low 2 clk while in_valid=1 every clk in RUN ->
//    in_drop_cnt=2, cic_nd absent those cycles.
//  4 backpressure: out_ready=0, 4 rdy pulses in RUN ->
//    FIFO keeps first 2 in order, out_drop_cnt=2; out_ready=1 -> 2 words out.
//  5 full push+pop: FIFO full, rdy and out_ready same cycle -> no drop, order kept.
//  6 restart mid-RUN with FIFO holding 1 word -> next clk out_valid=0, state CLEAR,
//    cic_sclr 4 clk, counters unchanged. Saturation: force CNT_W=2, 5 drops -> count 3.

Source files
------------

// File: rtl/cic_dec_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cic_dec_ctrl_pkg
// Purpose: Shared state encoding and default widths for the CIC decimator
//          sequencer (cic_dec_ctrl) and its interface.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package cic_dec_ctrl_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_WAIT_RFD = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam int DW_DEFAULT    = 18;
  localparam int CNT_W_DEFAULT = 16;

endpackage : cic_dec_ctrl_pkg
`default_nettype wire

// File: rtl/cic_dec_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cic_dec_ctrl_if
// Purpose: Bundles the sample input, CIC core handshake, downstream output
//          and status signals of cic_dec_ctrl.
// Ports  : master modport = controller side, slave modport = environment
//          (ADC, CIC core, downstream consumer).
// Rev    : 1.0  initial release
// ============================================================================
interface cic_dec_ctrl_if
  import cic_dec_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             restart;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             cic_sclr;
  logic [DW-1:0]    cic_din;
  logic             cic_nd;
  logic             cic_rfd;
  logic             cic_rdy;
  logic [DW-1:0]    cic_dout;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic             running;
  logic [CNT_W-1:0] in_drop_cnt;
  logic [CNT_W-1:0] out_drop_cnt;

  modport master (
    input  restart, in_valid, in_data, cic_rfd, cic_rdy, cic_dout, out_ready,
    output cic_sclr, cic_din, cic_nd, out_valid, out_data, running,
           in_drop_cnt, out_drop_cnt
  );

  modport slave (
    output restart, in_valid, in_data, cic_rfd, cic_rdy, cic_dout, out_ready,
    input  cic_sclr, cic_din, cic_nd, out_valid, out_data, running,
           in_drop_cnt, out_drop_cnt
  );

endinterface : cic_dec_ctrl_if
`default_nettype wire

// File: rtl/cic_out_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cic_out_fifo
// Purpose: 2-entry first-word-fall-through register FIFO for decimated
//          outputs. Head is always presented on out_data.
// Ports  : clk, sclr (async reset), flush (sync empty), push/push_data,
//          pop, out_valid/out_data (head), full.
// Rev    : 1.0  initial release
// ============================================================================
module cic_out_fifo #(
  parameter int DW = 18
) (
  input  wire logic          clk,
  input  wire logic          sclr,
  input  wire logic          flush,
  input  wire logic          push,
  input  wire logic [DW-1:0] push_data,
  input  wire logic          pop,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               full
);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          w_pop;
  logic          w_push;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    w_pop   = pop && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves this cycle
    w_push  = push && ((count_q != 2'd2) || w_pop);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (w_push) begin
            head_d  = push_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            head_d = push_data;
          end else if (w_push) begin
            tail_d  = push_data;
            count_d = 2'd2;
          end else if (w_pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            head_d = tail_q;
            if (w_push) tail_d = push_data;
            else        count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign full      = (count_q == 2'd2);

endmodule : cic_out_fifo
`default_nettype wire

// File: rtl/cic_dec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cic_dec_ctrl
// Purpose: Sequencer for a CIC decimator core. Clears the core, gates ADC
//          samples into it against rfd, discards the settling outputs after
//          a clear, buffers decimated outputs in a 2-entry FIFO and counts
//          input/output overruns with saturating counters.
// Ports  : clk, sclr (async active-high reset), bus (cic_dec_ctrl_if.master:
//          restart, ADC input, CIC core handshake, downstream output,
//          running and drop counters).
// Rev    : 1.0  initial release
// ============================================================================
module cic_dec_ctrl
  import cic_dec_ctrl_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int SCLR_CYCLES = 4,
  parameter int FLUSH_OUTS  = 3,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  wire logic      clk,
  input  wire logic      sclr,
  cic_dec_ctrl_if.master bus
);

  localparam int SCW = $clog2(SCLR_CYCLES + 1);
  localparam int FLW = (FLUSH_OUTS > 0) ? $clog2(FLUSH_OUTS + 1) : 1;
  localparam logic [SCW-1:0] SCLR_LOAD  = SCW'(SCLR_CYCLES);
  localparam logic [FLW-1:0] FLUSH_LOAD = FLW'(FLUSH_OUTS);

  state_t           state_q, state_d;
  logic [SCW-1:0]   sclr_cnt_q, sclr_cnt_d;
  logic [FLW-1:0]   flush_cnt_q, flush_cnt_d;
  logic             cic_sclr_q, cic_sclr_d;
  logic [DW-1:0]    cic_din_q, cic_din_d;
  logic             cic_nd_q, cic_nd_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] in_drop_q, in_drop_d;
  logic [CNT_W-1:0] out_drop_q, out_drop_d;

  logic w_active;
  logic w_push;
  logic w_fifo_flush;
  logic w_full;
  logic w_out_valid;
  logic w_pop;

  assign w_pop = w_out_valid && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    sclr_cnt_d   = sclr_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    cic_din_d    = cic_din_q;
    cic_nd_d     = 1'b0;
    in_drop_d    = in_drop_q;
    out_drop_d   = out_drop_q;
    w_push       = 1'b0;
    w_fifo_flush = 1'b0;
    w_active     = (state_q == ST_FLUSH) || (state_q == ST_RUN);

    if (bus.restart) begin
      // Restart overrides every other event this cycle; counters keep values
      state_d      = ST_CLEAR;
      sclr_cnt_d   = SCLR_LOAD;
      cic_din_d    = '0;
      w_fifo_flush = 1'b1;
    end else begin
      // Input gating: samples only reach the core once it is out of clear
      if (w_active) begin
        if (bus.in_valid && bus.cic_rfd) begin
          cic_din_d = bus.in_data;
          cic_nd_d  = 1'b1;
        end else if (bus.in_valid && (in_drop_q != '1)) begin
          in_drop_d = in_drop_q + CNT_W'(1);
        end
      end else begin
        cic_din_d = '0;
      end

      // Output capture: only RUN outputs are kept; settling outputs are dropped
      if ((state_q == ST_RUN) && bus.cic_rdy) begin
        if (!w_full || w_pop) begin
          w_push = 1'b1;
        end else if (out_drop_q != '1) begin
          out_drop_d = out_drop_q + CNT_W'(1);
        end
      end

      case (state_q)
        ST_CLEAR: begin
          if (sclr_cnt_q <= SCW'(1)) state_d = ST_WAIT_RFD;
          else                       sclr_cnt_d = sclr_cnt_q - SCW'(1);
        end
        ST_WAIT_RFD: begin
          if (bus.cic_rfd) begin
            if (FLUSH_OUTS == 0) begin
              state_d = ST_RUN;
            end else begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          if (bus.cic_rdy) begin
            if (flush_cnt_q <= FLW'(1)) state_d = ST_RUN;
            else                        flush_cnt_d = flush_cnt_q - FLW'(1);
          end
        end
        default: ;
      endcase
    end

    // Status outputs are registered copies of the next state
    cic_sclr_d = (state_d == ST_CLEAR);
    running_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q     <= ST_CLEAR;
      sclr_cnt_q  <= SCLR_LOAD;
      flush_cnt_q <= '0;
      cic_sclr_q  <= 1'b1;
      cic_din_q   <= '0;
      cic_nd_q    <= 1'b0;
      running_q   <= 1'b0;
      in_drop_q   <= '0;
      out_drop_q  <= '0;
    end else begin
      state_q     <= state_d;
      sclr_cnt_q  <= sclr_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cic_sclr_q  <= cic_sclr_d;
      cic_din_q   <= cic_din_d;
      cic_nd_q    <= cic_nd_d;
      running_q   <= running_d;
      in_drop_q   <= in_drop_d;
      out_drop_q  <= out_drop_d;
    end
  end

  cic_out_fifo #(
    .DW (DW)
  ) u_out_fifo (
    .clk       (clk),
    .sclr      (sclr),
    .flush     (w_fifo_flush),
    .push      (w_push),
    .push_data (bus.cic_dout),
    .pop       (bus.out_ready),
    .out_valid (w_out_valid),
    .out_data  (bus.out_data),
    .full      (w_full)
  );

  assign bus.out_valid    = w_out_valid;
  assign bus.cic_sclr     = cic_sclr_q;
  assign bus.cic_din      = cic_din_q;
  assign bus.cic_nd       = cic_nd_q;
  assign bus.running      = running_q;
  assign bus.in_drop_cnt  = in_drop_q;
  assign bus.out_drop_cnt = out_drop_q;

endmodule : cic_dec_ctrl
`default_nettype wire

// File: tb/tb_cic_dec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_cic_dec_ctrl
// Purpose: Self-checking bench for cic_dec_ctrl. A behavioural core stub is
//          driven with rfd/rdy patterns; expected outputs come from a
//          queue-based reference model. A second instance with 2-bit
//          counters shares the stimulus to exercise counter saturation.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cic_dec_ctrl;

  localparam int DW      = 18;
  localparam int SCLR_N  = 4;
  localparam int FLUSH_N = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SAT_MAX = 3;

  localparam int P_CLEAR = 0;
  localparam int P_WAIT  = 1;
  localparam int P_FLUSH = 2;
  localparam int P_RUN   = 3;

  logic clk = 1'b0;
  logic sclr;
  always #6.25 clk = ~clk;

  cic_dec_ctrl_if #(.DW(DW), .CNT_W(CNT_W)) bus ();
  cic_dec_ctrl_if #(.DW(DW), .CNT_W(2))     bus_s ();

  assign bus_s.restart   = bus.restart;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.cic_rfd   = bus.cic_rfd;
  assign bus_s.cic_rdy   = bus.cic_rdy;
  assign bus_s.cic_dout  = bus.cic_dout;
  assign bus_s.out_ready = bus.out_ready;

  cic_dec_ctrl #(
    .DW(DW), .SCLR_CYCLES(SCLR_N), .FLUSH_OUTS(FLUSH_N), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  cic_dec_ctrl #(
    .DW(DW), .SCLR_CYCLES(SCLR_N), .FLUSH_OUTS(FLUSH_N), .CNT_W(2)
  ) dut_sat (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus_s)
  );

  // ---------------- reference model ----------------
  int            m_phase;
  int            m_clr_left;
  int            m_flush_left;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_din;
  bit            m_nd;
  int            m_in_drop;
  int            m_out_drop;

  always @(posedge clk or posedge sclr) begin
    if (sclr) begin
      m_phase      = P_CLEAR;
      m_clr_left   = SCLR_N;
      m_flush_left = 0;
      m_q.delete();
      m_din        = '0;
      m_nd         = 1'b0;
      m_in_drop    = 0;
      m_out_drop   = 0;
    end else if (bus.restart) begin
      m_phase    = P_CLEAR;
      m_clr_left = SCLR_N;
      m_q.delete();
      m_din      = '0;
      m_nd       = 1'b0;
    end else begin
      automatic int  old = m_phase;
      automatic bit  pop = (m_q.size() > 0) && bus.out_ready;
      automatic bit  active = (old == P_FLUSH) || (old == P_RUN);
      m_nd = 1'b0;
      if (!active) begin
        m_din = '0;
      end else if (bus.in_valid && bus.cic_rfd) begin
        m_din = bus.in_data;
        m_nd  = 1'b1;
      end else if (bus.in_valid) begin
        m_in_drop = (m_in_drop < CNT_MAX) ? m_in_drop + 1 : CNT_MAX;
      end
      if (pop) void'(m_q.pop_front());
      if (old == P_RUN && bus.cic_rdy) begin
        if (m_q.size() < 2) m_q.push_back(bus.cic_dout);
        else m_out_drop = (m_out_drop < CNT_MAX) ? m_out_drop + 1 : CNT_MAX;
      end
      if (old == P_CLEAR) begin
        m_clr_left--;
        if (m_clr_left == 0) m_phase = P_WAIT;
      end else if (old == P_WAIT) begin
        if (bus.cic_rfd) begin
          m_phase      = P_FLUSH;
          m_flush_left = FLUSH_N;
        end
      end else if (old == P_FLUSH) begin
        if (bus.cic_rdy) begin
          m_flush_left--;
          if (m_flush_left == 0) m_phase = P_RUN;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    else             n_pass++;
  endtask

  function automatic int sat3(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  task automatic compare_all();
    check("cic_sclr",  32'(bus.cic_sclr),  32'(m_phase == P_CLEAR));
    check("running",   32'(bus.running),   32'(m_phase == P_RUN));
    check("cic_nd",    32'(bus.cic_nd),    32'(m_nd));
    check("cic_din",   32'(bus.cic_din),   32'(m_din));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", 32'(bus.out_data), 32'(m_q[0]));
    check("in_drop_cnt",      32'(bus.in_drop_cnt),    32'(m_in_drop));
    check("out_drop_cnt",     32'(bus.out_drop_cnt),   32'(m_out_drop));
    check("in_drop_cnt_sat",  32'(bus_s.in_drop_cnt),  32'(sat3(m_in_drop)));
    check("out_drop_cnt_sat", 32'(bus_s.out_drop_cnt), 32'(sat3(m_out_drop)));
  endtask

  // ---------------- stimulus ----------------
  // mode 0: bring-up, mode 1: fully random with occasional restart,
  // mode 2: backpressure, mode 3: continuous push+pop, mode 4: input overrun
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
      bus.restart  = 1'b0;
      bus.cic_dout = DW'($urandom);
      case (mode)
        0: begin
          bus.cic_rfd   = 1'b1;
          bus.cic_rdy   = ((i % 8) == 7);
          bus.in_valid  = 1'b1;
          bus.in_data   = DW'(100);
          bus.out_ready = 1'b1;
        end
        1: begin
          bus.cic_rfd   = ($urandom % 4) != 0;
          bus.cic_rdy   = ($urandom % 3) == 0;
          bus.in_valid  = $urandom % 2;
          bus.in_data   = DW'($urandom);
          bus.out_ready = $urandom % 2;
          bus.restart   = ($urandom % 60) == 0;
        end
        2: begin
          bus.cic_rfd   = 1'b1;
          bus.cic_rdy   = ($urandom % 3) == 0;
          bus.in_valid  = $urandom % 2;
          bus.in_data   = DW'($urandom);
          bus.out_ready = 1'b0;
        end
        3: begin
          bus.cic_rfd   = 1'b1;
          bus.cic_rdy   = 1'b1;
          bus.in_valid  = 1'b1;
          bus.in_data   = DW'($urandom);
          bus.out_ready = 1'b1;
        end
        default: begin
          bus.cic_rfd   = $urandom % 2;
          bus.cic_rdy   = ($urandom % 4) == 0;
          bus.in_valid  = 1'b1;
          bus.in_data   = DW'($urandom);
          bus.out_ready = 1'b1;
        end
      endcase
    end
  endtask

  initial begin
    sclr          = 1'b1;
    bus.restart   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cic_rfd   = 1'b0;
    bus.cic_rdy   = 1'b0;
    bus.cic_dout  = '0;
    bus.out_ready = 1'b0;
    #100;
    @(negedge clk);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    compare_all();
    sclr = 1'b0;

    run_cycles(60, 0);   // clear, settle, first kept output
    run_cycles(30, 4);   // rfd dropping with in_valid held high
    run_cycles(40, 2);   // FIFO fills and drops under backpressure
    run_cycles(10, 3);   // full FIFO with simultaneous push and pop
    run_cycles(20, 2);
    run_cycles(20, 0);   // drain
    run_cycles(800, 1);  // random traffic with restarts
    run_cycles(30, 2);
    run_cycles(200, 4);
    run_cycles(400, 1);
    @(negedge clk);
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cic_dec_ctrl
`default_nettype wire
